// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - debounced single-step and optional auto-run step generator
//
// Ports:
//   clk        board clock, all logic on rising edge
//   reset      synchronous active-low reset
//   btn_n      raw step button, asynchronous, active-low
//   run        auto-run switch, asynchronous, 1 = run (used only with STEP_CTRL_AUTORUN_EN)
//   halt       synchronous; 1 suppresses every step pulse, requests are dropped
//   step       one-cycle step enable to the processor
//   pressed    debounced button state, 1 = held
//   step_count step pulses issued, modulo 2**CNT_W
//
// Optional feature macro: STEP_CTRL_AUTORUN_EN (run synchroniser, divider, auto-step)
module step_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int RUN_DIV    = 25000000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_n,
    input  logic             run,
    input  logic             halt,
    output logic             step,
    output logic             pressed,
    output logic [CNT_W-1:0] step_count
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_cnt_next;
    logic [1:0]       btn_sync;
    logic             btn_s;
    logic             man_edge;
    logic             man_req;
    logic             auto_req;
    logic             req_q;

    // Preset to 1 so a reset never looks like a button press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_sync <= 2'b11;
        end else begin
            btn_sync <= {btn_sync[0], btn_n};
        end
    end

    assign btn_s = btn_sync[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            state   <= state_next;
            deb_cnt <= deb_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        deb_cnt_next = deb_cnt;
        case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_next   = PRESS_WAIT;
                    deb_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_next = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = HELD;
                end else begin
                    deb_cnt_next = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (btn_s) begin
                    state_next   = RELEASE_WAIT;
                    deb_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    state_next = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = IDLE;
                end else begin
                    deb_cnt_next = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                deb_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        pressed  = (state == HELD) || (state == RELEASE_WAIT);
        // True only in the cycle that commits PRESS_WAIT -> HELD.
        man_edge = (state == PRESS_WAIT) && !btn_s && (deb_cnt == DEB_LAST);
    end

`ifdef STEP_CTRL_AUTORUN_EN
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [1:0]       run_sync;
    logic             run_s;
    logic             run_q;
    logic [DIV_W-1:0] div;

    assign run_s = run_sync[1];

    // run_q delays the divider start by one cycle so the first auto-step
    // lands RUN_DIV+3 edges after run is sampled; dropping run_s stops it at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_sync <= 2'b00;
            run_q    <= 1'b0;
            div      <= '0;
        end else begin
            run_sync <= {run_sync[0], run};
            run_q    <= run_s;
            if (run_s && run_q) begin
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end else begin
                div <= '0;
            end
        end
    end

    assign auto_req = run_s && run_q && (div == DIV_LAST);
    assign man_req  = man_edge && !run_s;
`else
    logic unused_cfg;

    assign unused_cfg = run ^ (RUN_DIV < 2);
    assign auto_req   = 1'b0;
    assign man_req    = man_edge;
`endif

    // Requests are registered once, then gated by halt into the step flop;
    // a request seen while halted is simply lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q      <= 1'b0;
            step       <= 1'b0;
            step_count <= '0;
        end else begin
            req_q <= man_req || auto_req;
            step  <= req_q && !halt;
            if (step) begin
                step_count <= step_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - scoreboard bench for step_ctrl with randomized stimulus
module tb_step_ctrl;

    localparam int DEB  = 4;
    localparam int RDIV = 8;
    localparam int CW   = 4;
`ifdef STEP_CTRL_AUTORUN_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_n;
    logic          run;
    logic          halt;
    logic          step;
    logic          pressed;
    logic [CW-1:0] step_count;

    step_ctrl #(
        .DEB_CYCLES(DEB),
        .RUN_DIV   (RDIV),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_n     (btn_n),
        .run       (run),
        .halt      (halt),
        .step      (step),
        .pressed   (pressed),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    bit            b_d1 = 1'b1, b_d2 = 1'b1, r_d1 = 1'b0, r_d2 = 1'b0;
    bit            bs, rs;
    bit            deb = 1'b0, pend = 1'b0, stepped = 1'b0;
    int            dis = 0, hi = 0;
    logic [CW-1:0] mcount = '0;
    int            sb_q[$];

    // monitor state
    bit mon_en = 1'b0, prev_pressed = 1'b0, exp_step;
    int nsteps = 0, nrises = 0, last_step = -1, last_rise = -1;
    int seen_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: debounced level flips after DEB+1 consecutive disagreeing
    // synchronised samples; auto-steps every RUN_DIV edges of continuous run.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            b_d1 = 1'b1; b_d2 = 1'b1; r_d1 = 1'b0; r_d2 = 1'b0;
            deb = 1'b0; dis = 0; hi = 0; pend = 1'b0; stepped = 1'b0;
            mcount = '0;
        end else begin
            bs = b_d2;
            rs = (AUTO != 0) && r_d2;
            if (stepped) mcount = mcount + 1'b1;
            stepped = 1'b0;
            if (pend && !halt) begin
                sb_q.push_back(cyc);
                stepped = 1'b1;
            end
            pend = 1'b0;
            if (bs == deb) begin
                dis++;
                if (dis == DEB + 1) begin
                    deb = !deb;
                    dis = 0;
                    if (deb && !rs) pend = 1'b1;
                end
            end else begin
                dis = 0;
            end
            if (rs) begin
                hi++;
                if (hi > 1 && (hi - 1) % RDIV == 0) pend = 1'b1;
            end else begin
                hi = 0;
            end
            b_d2 = b_d1; b_d1 = btn_n;
            r_d2 = r_d1; r_d1 = run;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_step = (sb_q.size() > 0) && (sb_q[0] == cyc);
            if (exp_step) void'(sb_q.pop_front());
            chk($sformatf("step@%0d", cyc), step, exp_step);
            chk($sformatf("pressed@%0d", cyc), pressed, deb);
            chk($sformatf("step_count@%0d", cyc), step_count, mcount);
            if (step) begin
                nsteps++;
                last_step = cyc;
                seen_q.push_back(cyc);
            end
            if (pressed && !prev_pressed) begin
                nrises++;
                last_rise = cyc;
            end
            prev_pressed = pressed;
        end
    end

    initial begin
        int t0, r0, n0, base;
        reset = 1'b0; btn_n = 1'b1; run = 1'b0; halt = 1'b0;
        wait_cyc(3);
        mon_en = 1'b1;
        chk("reset_step", step, 0);
        chk("reset_pressed", pressed, 0);
        chk("reset_count", step_count, 0);
        reset = 1'b1;
        wait_cyc(3);

        // clean press
        t0 = cyc + 1; n0 = nsteps;
        btn_n = 1'b0; wait_cyc(20);
        btn_n = 1'b1; wait_cyc(12);
        chk("press_nsteps", nsteps - n0, 1);
        chk("press_step_edge", last_step, t0 + DEB + 3);
        chk("press_rise_edge", last_rise, t0 + DEB + 2);
        chk("press_count", step_count, 1);

        // bounce
        n0 = nsteps; base = nrises;
        btn_n = 1'b0; wait_cyc(1);
        btn_n = 1'b1; wait_cyc(1);
        btn_n = 1'b0; wait_cyc(2);
        btn_n = 1'b1; wait_cyc(12);
        chk("bounce_nsteps", nsteps - n0, 0);
        chk("bounce_rises", nrises - base, 0);
        chk("bounce_pressed", pressed, 0);

        // auto-run
        r0 = cyc + 1; n0 = nsteps; base = seen_q.size();
        run = 1'b1; wait_cyc(40);
        run = 1'b0; wait_cyc(12);
        chk("auto_nsteps", nsteps - n0, 4 * AUTO);
        for (int k = 0; k < seen_q.size() - base; k++)
            chk($sformatf("auto_edge%0d", k), seen_q[base + k], r0 + RDIV + 3 + k * RDIV);
        chk("auto_count", step_count, 1 + 4 * AUTO);

        // halt
        r0 = cyc + 1; n0 = nsteps;
        halt = 1'b1; run = 1'b1; wait_cyc(40);
        chk("halt_nsteps", nsteps - n0, 0);
        halt = 1'b0; base = seen_q.size(); n0 = nsteps;
        wait_cyc(6);
        chk("halt_resume_n", nsteps - n0, AUTO);
        for (int k = 0; k < seen_q.size() - base; k++)
            chk("halt_resume_edge", seen_q[base + k], r0 + 5 * RDIV + 3);
        run = 1'b0; wait_cyc(12);

        // wrap
        reset = 1'b0; wait_cyc(2);
        chk("wrap_reset_count", step_count, 0);
        reset = 1'b1; wait_cyc(2);
        for (int i = 0; i < 16; i++) begin
            btn_n = 1'b0; wait_cyc(8);
            btn_n = 1'b1; wait_cyc(8);
            if (i == 14) chk("wrap_count15", step_count, 15);
        end
        chk("wrap_count0", step_count, 0);

        // reset mid PRESS_WAIT with button held
        btn_n = 1'b0; wait_cyc(4);
        reset = 1'b0; wait_cyc(2);
        chk("midreset_step", step, 0);
        chk("midreset_pressed", pressed, 0);
        chk("midreset_count", step_count, 0);
        t0 = cyc + 1; n0 = nsteps;
        reset = 1'b1; wait_cyc(12);
        chk("midreset_nsteps", nsteps - n0, 1);
        chk("midreset_step_edge", last_step, t0 + DEB + 3);
        btn_n = 1'b1; wait_cyc(10);

        // randomized phase, checked by the scoreboard
        for (int i = 0; i < 60; i++) begin
            halt = ($urandom_range(0, 3) == 0);
            run  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b0; wait_cyc($urandom_range(1, 3));
                reset = 1'b1;
            end else begin
                btn_n = 1'b0; wait_cyc($urandom_range(1, 10));
                btn_n = 1'b1; wait_cyc($urandom_range(1, 10));
            end
        end
        run = 1'b0; halt = 1'b0; btn_n = 1'b1;
        wait_cyc(20);
        chk("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
